// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcode/FUNCT3 encodings, FSM states
// and the operation decode used by the exec unit and its logic sub-block.
package alu_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    // Non-ALU opcodes (loads, stores, LUI, AUIPC) only ever need address addition.
    function automatic alu_op_e decode_op(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       funct1);
        alu_op_e op;
        op = ALU_ADD;
        if ((opcode == OP_IMM) || (opcode == OP_REG)) begin
            case (funct3)
                F3_ADD:  op = ((opcode == OP_REG) && funct1) ? ALU_SUB : ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SR:   op = funct1 ? ALU_SRA : ALU_SRL;
                F3_OR:   op = ALU_OR;
                F3_AND:  op = ALU_AND;
                default: op = ALU_ADD;
            endcase
        end else begin
            op = ALU_ADD;
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational single-cycle ALU path: add/sub, compares and bitwise ops.
// Shift operations are handled iteratively by the exec unit, not here.
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  alu_op_e        op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   y
);

    logic lt_s;
    logic ltu_s;

    assign lt_s  = $signed(a) < $signed(b);
    assign ltu_s = a < b;

    // Single-cycle result select; arithmetic wraps modulo 2^N.
    always_comb begin
        y = {N{1'b0}};
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {{(N-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(N-1){1'b0}}, ltu_s};
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Single-cycle ops
// finish in one cycle; shifts iterate SHIFT_STEP bits per cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int N          = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           FLUSH,
    input  logic           ALU_EN,
    output logic           IN_READY,
    input  logic [N-1:0]   DATA0,
    input  logic [N-1:0]   DATA1,
    input  logic [6:0]     OPCODE,
    input  logic [2:0]     FUNCT3,
    input  logic           FUNCT1,
    output logic [N-1:0]   RESULT,
    output logic           RESULT_VALID,
    input  logic           RESULT_READY
);

    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    // One extra bit so a step as large as N is representable.
    localparam int CWP = CW + 1;
    localparam logic [CWP-1:0] STEP_C = CWP'(SHIFT_STEP);

    state_e          state_r, state_n;
    logic [N-1:0]    result_r, result_n;
    logic            valid_r;
    logic [N-1:0]    acc_r, acc_n;
    logic [CWP-1:0]  rem_r, rem_n;
    alu_op_e         shop_r, shop_n;

    alu_op_e         op_s;
    logic            is_shift_s;
    logic [CW-1:0]   shamt_s;
    logic            go_shift_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [N-1:0]    logic_y_s;
    logic [CWP-1:0]  step_s;
    logic [N-1:0]    shifted_s;

    assign op_s       = decode_op(OPCODE, FUNCT3, FUNCT1);
    assign is_shift_s = (op_s == ALU_SLL) || (op_s == ALU_SRL) || (op_s == ALU_SRA);
    assign shamt_s    = DATA1[CW-1:0];
    assign go_shift_s = is_shift_s && (shamt_s != {CW{1'b0}});
    assign in_ready_s = !FLUSH && ((state_r == IDLE) || ((state_r == DONE) && RESULT_READY));
    assign accept_s   = ALU_EN && in_ready_s;
    assign step_s     = (rem_r > STEP_C) ? STEP_C : rem_r;

    assign IN_READY     = in_ready_s;
    assign RESULT       = result_r;
    assign RESULT_VALID = valid_r;

    alu_logic_unit #(.N(N)) u_logic (
        .op (op_s),
        .a  (DATA0),
        .b  (DATA1),
        .y  (logic_y_s)
    );

    // One shift step; SRA keeps replicating the MSB, which is the original sign.
    always_comb begin
        shifted_s = acc_r;
        case (shop_r)
            ALU_SLL: shifted_s = acc_r << step_s;
            ALU_SRL: shifted_s = acc_r >> step_s;
            ALU_SRA: shifted_s = unsigned'($signed(acc_r) >>> step_s);
            default: shifted_s = acc_r;
        endcase
    end

    // Next-state decode; FLUSH overrides every other transition.
    always_comb begin
        state_n = state_r;
        if (FLUSH) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_n = go_shift_s ? SHIFT : DONE;
                    end else begin
                        state_n = IDLE;
                    end
                end
                SHIFT: begin
                    if (rem_r <= STEP_C) begin
                        state_n = DONE;
                    end else begin
                        state_n = SHIFT;
                    end
                end
                DONE: begin
                    if (!RESULT_READY) begin
                        state_n = DONE;
                    end else if (accept_s) begin
                        state_n = go_shift_s ? SHIFT : DONE;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath next values; RESULT only changes on the way into DONE.
    always_comb begin
        acc_n    = acc_r;
        rem_n    = rem_r;
        shop_n   = shop_r;
        result_n = result_r;
        if (FLUSH) begin
            result_n = result_r;
        end else if (accept_s) begin
            acc_n  = DATA0;
            rem_n  = {1'b0, shamt_s};
            shop_n = op_s;
            if (!is_shift_s) begin
                result_n = logic_y_s;
            end else if (!go_shift_s) begin
                result_n = DATA0;
            end else begin
                result_n = result_r;
            end
        end else if (state_r == SHIFT) begin
            acc_n = shifted_s;
            rem_n = rem_r - step_s;
            if (rem_r <= STEP_C) begin
                result_n = shifted_s;
            end else begin
                result_n = result_r;
            end
        end else begin
            result_n = result_r;
        end
    end

    // State, result and shift-iterator registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            result_r <= {N{1'b0}};
            valid_r  <= 1'b0;
            acc_r    <= {N{1'b0}};
            rem_r    <= {CWP{1'b0}};
            shop_r   <= ALU_ADD;
        end else begin
            state_r  <= state_n;
            result_r <= result_n;
            valid_r  <= (state_n == DONE);
            acc_r    <= acc_n;
            rem_r    <= rem_n;
            shop_r   <= shop_n;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed feature tasks plus a random
// back-pressured stream, all checked through an expected-result queue.
module tb_alu_exec_unit;

    localparam int N = 32;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           FLUSH;
    logic           ALU_EN;
    logic           IN_READY;
    logic [N-1:0]   DATA0;
    logic [N-1:0]   DATA1;
    logic [6:0]     OPCODE;
    logic [2:0]     FUNCT3;
    logic           FUNCT1;
    logic [N-1:0]   RESULT;
    logic           RESULT_VALID;
    logic           RESULT_READY;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] sb_q[$];

    always #5 CLK = ~CLK;

    alu_exec_unit #(.N(N), .SHIFT_STEP(1)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .FLUSH        (FLUSH),
        .ALU_EN       (ALU_EN),
        .IN_READY     (IN_READY),
        .DATA0        (DATA0),
        .DATA1        (DATA1),
        .OPCODE       (OPCODE),
        .FUNCT3       (FUNCT3),
        .FUNCT1       (FUNCT1),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_READY (RESULT_READY)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                         input logic [31:0] a, input logic [31:0] b);
        OPCODE = opc;
        FUNCT3 = f3;
        FUNCT1 = f1;
        DATA0  = a;
        DATA1  = b;
    endtask

    // Reference behaviour of one operation, written from the ISA semantics.
    function automatic logic [31:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic f1, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (opc != 7'h33 && opc != 7'h13) return a + b;
        case (f3)
            3'd0: return (opc == 7'h33 && f1) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f1 ? unsigned'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f1, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy;
        logic [31:0] e;
        drive(opc, f3, f1, a, b);
        ALU_EN = 1'b1;
        RESULT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready: got %b expected 1", name, IN_READY);
        end
        sb_q.push_back(exp);
        tick;
        ALU_EN = 1'b0;
        lat = 1;
        busy = 0;
        while (RESULT_VALID !== 1'b1 && lat < 64) begin
            if (IN_READY === 1'b0) busy++;
            tick;
            lat++;
        end
        checks++;
        if (RESULT_VALID !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: got valid=%b expected 1", name, RESULT_VALID);
            sb_q.delete();
        end else begin
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            checks++;
            if (busy != exp_lat - 1) begin
                failures++;
                $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy, exp_lat - 1);
            end
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (RESULT !== e) begin
                failures++;
                $display("FAIL %s result: got %h expected %h", name, RESULT, e);
            end
        end
        tick;
        checks++;
        if (RESULT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL %s valid_one_cycle: got %b expected 0", name, RESULT_VALID);
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; FLUSH = 1'b0; ALU_EN = 1'b0; RESULT_READY = 1'b1;
        drive(7'h33, 3'd0, 1'b0, 32'd0, 32'd0);
        #3;
        checks++;
        if (RESULT !== 32'd0) begin
            failures++; $display("FAIL reset_result: got %h expected 0", RESULT);
        end
        checks++;
        if (RESULT_VALID !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", RESULT_VALID);
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY);
        end
        #10;
        RST_N = 1'b1;
        tick;
    endtask

    task automatic test_single_cycle;
        run_op("add",     7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'd12, 1);
        run_op("sub",     7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
        run_op("addi_f1", 7'h13, 3'd0, 1'b1, 32'd5, 32'd7, 32'd12, 1);
        run_op("slt",     7'h33, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
        run_op("sltu",    7'h33, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
        run_op("slti",    7'h13, 3'd2, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1);
        run_op("xor",     7'h33, 3'd4, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1);
        run_op("or",      7'h33, 3'd6, 1'b0, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1);
        run_op("and",     7'h33, 3'd7, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1);
        run_op("load_add", 7'h03, 3'd4, 1'b1, 32'd5, 32'd7, 32'd12, 1);
        run_op("add_wrap", 7'h33, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd1, 1);
    endtask

    task automatic test_shift;
        run_op("sra4",      7'h33, 3'd5, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 5);
        run_op("sra_hi",    7'h33, 3'd5, 1'b1, 32'h80000000, 32'h24, 32'hF8000000, 5);
        run_op("sra0",      7'h33, 3'd5, 1'b1, 32'h80000000, 32'h20, 32'h80000000, 1);
        run_op("sll31",     7'h33, 3'd1, 1'b0, 32'd1, 32'd31, 32'h80000000, 32);
        run_op("srl8",      7'h33, 3'd5, 1'b0, 32'hF0000000, 32'd8, 32'h00F00000, 9);
        run_op("srai1",     7'h13, 3'd5, 1'b1, 32'h80000010, 32'd1, 32'hC0000008, 2);
    endtask

    task automatic test_backpressure;
        logic [31:0] x_exp;
        drive(7'h33, 3'd0, 1'b0, 32'd3, 32'd4);
        RESULT_READY = 1'b0;
        ALU_EN = 1'b1;
        #1;
        sb_q.push_back(32'd7);
        tick;
        drive(7'h33, 3'd4, 1'b0, 32'hF0F0F0F0, 32'h0F0F00FF);
        x_exp = 32'hFFFFF00F;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (RESULT_VALID !== 1'b1 || RESULT !== sb_q[0]) begin
                failures++;
                $display("FAIL hold_%0d: got valid=%b result=%h expected valid=1 result=%h",
                         k, RESULT_VALID, RESULT, sb_q[0]);
            end
            checks++;
            if (IN_READY !== 1'b0) begin
                failures++; $display("FAIL hold_in_ready_%0d: got %b expected 0", k, IN_READY);
            end
            tick;
        end
        RESULT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++; $display("FAIL release_in_ready: got %b expected 1", IN_READY);
        end
        checks++;
        if (RESULT !== sb_q.pop_front()) begin
            failures++; $display("FAIL release_result: got %h expected 7", RESULT);
        end
        sb_q.push_back(x_exp);
        tick;
        ALU_EN = 1'b0;
        checks++;
        if (RESULT_VALID !== 1'b1 || RESULT !== sb_q[0]) begin
            failures++;
            $display("FAIL no_bubble: got valid=%b result=%h expected valid=1 result=%h",
                     RESULT_VALID, RESULT, sb_q[0]);
        end
        void'(sb_q.pop_front());
        tick;
        checks++;
        if (RESULT_VALID !== 1'b0) begin
            failures++; $display("FAIL bp_drain_valid: got %b expected 0", RESULT_VALID);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [31:0] e;
        RESULT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            f3 = (i % 2 == 0) ? 3'd0 : 3'd4;
            drive(7'h33, f3, 1'b0, a, b);
            ALU_EN = 1'b1;
            #1;
            checks++;
            if (IN_READY !== 1'b1) begin
                failures++; $display("FAIL b2b_in_ready_%0d: got %b expected 1", i, IN_READY);
            end
            sb_q.push_back(model(7'h33, f3, 1'b0, a, b));
            tick;
            e = sb_q.pop_front();
            checks++;
            if (RESULT_VALID !== 1'b1 || RESULT !== e) begin
                failures++;
                $display("FAIL b2b_%0d: got valid=%b result=%h expected valid=1 result=%h",
                         i, RESULT_VALID, RESULT, e);
            end
        end
        ALU_EN = 1'b0;
        tick;
    endtask

    task automatic test_flush;
        bit seen;
        drive(7'h13, 3'd1, 1'b0, 32'd1, 32'd20);
        ALU_EN = 1'b1;
        RESULT_READY = 1'b1;
        #1;
        tick;
        ALU_EN = 1'b0;
        tick;
        tick;
        FLUSH = 1'b1;
        ALU_EN = 1'b1;
        drive(7'h33, 3'd0, 1'b0, 32'd1, 32'd1);
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            failures++; $display("FAIL flush_in_ready: got %b expected 0", IN_READY);
        end
        tick;
        FLUSH = 1'b0;
        ALU_EN = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1 || RESULT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: got in_ready=%b valid=%b expected 1 0", IN_READY, RESULT_VALID);
        end
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (RESULT_VALID === 1'b1) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL flush_no_valid: got valid seen=1 expected 0");
        end
    endtask

    task automatic test_async_reset;
        run_op("pre_reset_add", 7'h33, 3'd0, 1'b0, 32'h11, 32'h22, 32'h33, 1);
        drive(7'h33, 3'd5, 1'b0, 32'hF0000000, 32'd10);
        ALU_EN = 1'b1;
        #1;
        tick;
        ALU_EN = 1'b0;
        tick;
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (RESULT !== 32'd0 || RESULT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got result=%h valid=%b expected 0 0", RESULT, RESULT_VALID);
        end
        #1;
        RST_N = 1'b1;
        tick;
        run_op("post_reset_add", 7'h33, 3'd0, 1'b0, 32'd100, 32'd23, 32'd123, 1);
    endtask

    task automatic test_random;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] a;
        logic [31:0] b;
        int          r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 2);
            opc = (r == 0) ? 7'h33 : ((r == 1) ? 7'h13 : 7'h03);
            f3 = 3'($urandom_range(0, 7));
            f1 = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            drive(opc, f3, f1, a, b);
            ALU_EN = 1'($urandom_range(0, 1));
            RESULT_READY = ($urandom_range(0, 3) != 0);
            #1;
            if (RESULT_VALID === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected: got %h expected none", RESULT);
                end else if (RESULT !== sb_q[0]) begin
                    failures++; $display("FAIL rand_%0d: got %h expected %h", i, RESULT, sb_q[0]);
                end
                if (RESULT_READY && sb_q.size() > 0) void'(sb_q.pop_front());
            end
            if (ALU_EN && IN_READY === 1'b1) sb_q.push_back(model(opc, f3, f1, a, b));
            tick;
        end
        ALU_EN = 1'b0;
        RESULT_READY = 1'b1;
        for (int k = 0; k < 80 && sb_q.size() > 0; k++) begin
            if (RESULT_VALID === 1'b1) begin
                checks++;
                if (RESULT !== sb_q[0]) begin
                    failures++; $display("FAIL rand_drain: got %h expected %h", RESULT, sb_q[0]);
                end
                void'(sb_q.pop_front());
            end
            tick;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL rand_leftover: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
